// File: rtl/peripheral_bus_master_if.sv
// rtl/peripheral_bus_master_if.sv - host, register-window and memory-window signals of the bus master
// master modport faces the bus master; slave modport faces the host and peripheral side.
interface peripheral_bus_master_if;
    logic        cpu_req;
    logic        cpu_write;
    logic [31:0] cpu_address;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rdata;
    logic        cpu_error;

    logic        reg_read;
    logic        reg_write;
    logic [1:0]  reg_address;
    logic        reg_read_valid;
    logic [31:0] reg_data_out;

    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_address;
    logic        mem_read_valid;
    logic [31:0] mem_data_out;

    logic [31:0] wr_data;

    modport master (
        input  cpu_req, cpu_write, cpu_address, cpu_wdata,
        output cpu_ready, cpu_rsp_valid, cpu_rdata, cpu_error,
        output reg_read, reg_write, reg_address,
        input  reg_read_valid, reg_data_out,
        output mem_read, mem_write, mem_address,
        input  mem_read_valid, mem_data_out,
        output wr_data
    );

    modport slave (
        output cpu_req, cpu_write, cpu_address, cpu_wdata,
        input  cpu_ready, cpu_rsp_valid, cpu_rdata, cpu_error,
        input  reg_read, reg_write, reg_address,
        output reg_read_valid, reg_data_out,
        input  mem_read, mem_write, mem_address,
        output mem_read_valid, mem_data_out,
        input  wr_data
    );
endinterface

// File: rtl/peripheral_bus_master.sv
// rtl/peripheral_bus_master.sv - single-outstanding host-to-peripheral bridge
// Decodes a register window (0..15) and a memory window (1024..2047); reads time out after TIMEOUT_CYCLES.
module peripheral_bus_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    peripheral_bus_master_if.master bus
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP} state_t;
    typedef enum logic [1:0] {T_NONE, T_REG, T_MEM} target_t;

    state_t         r_state;
    state_t         w_next;
    target_t        r_target;
    target_t        w_decode;
    logic           r_write;
    logic [1:0]     r_reg_addr;
    logic [7:0]     r_mem_addr;
    logic [31:0]    r_wdata;
    logic [31:0]    r_rdata;
    logic           r_error;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_next;
    logic           w_accept;
    logic           w_load_rsp;
    logic [31:0]    w_rsp_rdata;
    logic           w_rsp_error;
    logic           w_rd_valid;
    logic [31:0]    w_rd_data;

    always_comb begin
        w_decode = T_NONE;
        if (bus.cpu_address < 32'd16)
            w_decode = T_REG;
        else if (bus.cpu_address >= 32'd1024 && bus.cpu_address < 32'd2048)
            w_decode = T_MEM;
    end

    // Only the targeted window's valid counts; the other window may be chattering.
    always_comb begin
        w_rd_valid = 1'b0;
        w_rd_data  = 32'd0;
        if (r_target == T_REG) begin
            w_rd_valid = bus.reg_read_valid;
            w_rd_data  = bus.reg_data_out;
        end else if (r_target == T_MEM) begin
            w_rd_valid = bus.mem_read_valid;
            w_rd_data  = bus.mem_data_out;
        end
    end

    assign w_accept = (r_state == S_IDLE) && bus.cpu_req;

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = '0;
        w_load_rsp  = 1'b0;
        w_rsp_rdata = 32'd0;
        w_rsp_error = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    if (w_decode == T_NONE) begin
                        w_next      = S_RESP;
                        w_load_rsp  = 1'b1;
                        w_rsp_error = 1'b1;
                    end else begin
                        w_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (r_write) begin
                    w_next     = S_RESP;
                    w_load_rsp = 1'b1;
                end else begin
                    w_next = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (w_rd_valid) begin
                    w_next      = S_RESP;
                    w_load_rsp  = 1'b1;
                    w_rsp_rdata = w_rd_data;
                end else if (r_cnt == CNT_LAST) begin
                    w_next      = S_RESP;
                    w_load_rsp  = 1'b1;
                    w_rsp_error = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_target   <= T_NONE;
            r_write    <= 1'b0;
            r_reg_addr <= 2'd0;
            r_mem_addr <= 8'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_error    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_target   <= w_decode;
                r_write    <= bus.cpu_write;
                r_reg_addr <= bus.cpu_address[3:2];
                r_mem_addr <= bus.cpu_address[9:2];
                r_wdata    <= bus.cpu_wdata;
            end
            if (w_load_rsp) begin
                r_rdata <= w_rsp_rdata;
                r_error <= w_rsp_error;
            end
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign bus.reg_read      = (r_state == S_ISSUE) && (r_target == T_REG) && !r_write;
    assign bus.reg_write     = (r_state == S_ISSUE) && (r_target == T_REG) &&  r_write;
    assign bus.mem_read      = (r_state == S_ISSUE) && (r_target == T_MEM) && !r_write;
    assign bus.mem_write     = (r_state == S_ISSUE) && (r_target == T_MEM) &&  r_write;
    assign bus.reg_address   = r_reg_addr;
    assign bus.mem_address   = r_mem_addr;
    assign bus.wr_data       = r_wdata;
    assign bus.cpu_ready     = (r_state == S_IDLE);
    assign bus.cpu_rsp_valid = (r_state == S_RESP);
    assign bus.cpu_rdata     = r_rdata;
    assign bus.cpu_error     = r_error;

endmodule
